axi_read_responder: RTL and testbench

//  AXI4 read-channel slave (AR/R only) backed by an internal 64-bit word memory.
//  It is the responder end of the line-fill reads issued by the instruction/data caches.

---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_addr_gen.sv | 30 +++
 rtl/axi_read_responder.sv | 130 +++++++++++++
 tb/tb_axi_read_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-channel types: burst encodings, response codes and the latched AR request.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  // burst is kept as raw bits so the reserved encoding 3 can still be latched and flagged
  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

  // True when the whole burst must answer SLVERR on every beat
  function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > 3'd3) || (burst == 2'b11) || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared with the cache fill logic.
module axi_addr_gen
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr
);

  logic [63:0] step;
  logic [63:0] wrap_mask;
  logic [63:0] incr_addr;

  assign step      = 64'd1 << size;
  assign wrap_mask = (({56'd0, len} + 64'd1) * step) - 64'd1;
  assign incr_addr = addr + step;

  // Reserved burst type holds the address; its beats are all errored anyway
  always_comb begin
    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read-only slave backed by a 64-bit word memory, one outstanding burst, fixed first-beat latency.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [63:0] load_data
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_e;

  state_e      state, next_state;
  ar_req_t     req;
  logic [3:0]  lat_cnt;
  logic [7:0]  beat_cnt;
  logic        bad_burst;
  logic [63:0] mem [MEM_WORDS];

  logic        ar_hs, beat_done, last_beat, load_first, advance;
  logic [63:0] next_addr, fetch_addr, fetch_off, fetch_data, load_off;
  logic        fetch_ok, load_ok;

  assign ar_hs     = s_axi_arvalid && s_axi_arready;
  assign beat_done = s_axi_rvalid && s_axi_rready;
  assign last_beat = (beat_cnt == req.len);

  axi_addr_gen u_addr_gen (
    .addr      (req.addr),
    .len       (req.len),
    .size      (req.size),
    .burst     (req.burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_first = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE:  if (ar_hs) next_state = ST_WAIT;
      ST_WAIT:  if (lat_cnt == 4'd0) begin
                  next_state = ST_BURST;
                  load_first = 1'b1;
                end
      ST_BURST: if (beat_done) begin
                  if (last_beat) next_state = ST_IDLE;
                  else           advance    = 1'b1;
                end
      default:  next_state = ST_IDLE;
    endcase
  end

  // The beat being loaded into the output register: the start address or the next one
  assign fetch_addr = load_first ? req.addr : next_addr;
  assign fetch_off  = fetch_addr - BASE_ADDR;
  assign fetch_ok   = (fetch_addr >= BASE_ADDR) && (fetch_off < MEM_BYTES);
  assign fetch_data = fetch_ok ? mem[fetch_off[IDX_W+2:3]] : 64'd0;

  assign load_off = load_addr - BASE_ADDR;
  assign load_ok  = (load_addr >= BASE_ADDR) && (load_off < MEM_BYTES);

  // Nonblocking write makes a same-edge read see the old word
  always_ff @(posedge clk) begin
    if (load_en && load_ok) mem[load_off[IDX_W+2:3]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 64'd0;
      s_axi_rresp   <= AXI_OKAY;
      s_axi_rlast   <= 1'b0;
      req           <= '0;
      lat_cnt       <= 4'd0;
      beat_cnt      <= 8'd0;
      bad_burst     <= 1'b0;
    end else begin
      s_axi_arready <= (next_state == ST_IDLE);
      if (ar_hs) begin
        req       <= '{addr: s_axi_araddr, len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
        lat_cnt   <= 4'(READ_LATENCY - 1);
        beat_cnt  <= 8'd0;
        bad_burst <= burst_illegal(s_axi_arsize, s_axi_arburst, s_axi_arlen);
      end
      if (state == ST_WAIT && lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
      // Output register only changes when a new beat is loaded, which keeps it stable under stalls
      if (load_first || advance) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= fetch_data;
        s_axi_rresp  <= (bad_burst || !fetch_ok) ? AXI_SLVERR : AXI_OKAY;
        s_axi_rlast  <= load_first ? (req.len == 8'd0) : ((beat_cnt + 8'd1) == req.len);
      end
      if (advance) begin
        req.addr <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (state == ST_BURST && beat_done && last_beat) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed self-checking bench for axi_read_responder with default parameters.
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        load_en;
  logic [63:0] load_addr;
  logic [63:0] load_data;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] exp_data [16];
  logic [1:0]  exp_resp [16];
  bit          exp_data_on [16];

  axi_read_responder dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for arready, then holds arvalid for exactly one handshake edge
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
    int waited = 0;
    while (!s_axi_arready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axi_arready) checkOutput("ar_timeout", 64'(s_axi_arready), 64'd1);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  // Collects n beats against exp_*; mode 1 drives rready 1,0,0,1,0,0...; stop_at>=0 leaves with beat stop_at presented
  task automatic collectBurst(input int n, input int mode, input int stop_at);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 200) begin
      if (stop_at >= 0 && k == stop_at && s_axi_rvalid) break;
      s_axi_rready = (mode == 0) || (cyc % 3 == 0);
      if (s_axi_rvalid) begin
        if (exp_data_on[k]) checkOutput($sformatf("rdata[%0d]", k), s_axi_rdata, exp_data[k]);
        checkOutput($sformatf("rresp[%0d]", k), 64'(s_axi_rresp), 64'(exp_resp[k]));
        checkOutput($sformatf("rlast[%0d]", k), 64'(s_axi_rlast), 64'(k == n - 1));
        checkOutput($sformatf("arready_busy[%0d]", k), 64'(s_axi_arready), 64'd0);
        if (s_axi_rready) k++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (stop_at < 0) begin
      checkOutput("beat_count", 64'(k), 64'(n));
      checkOutput("rvalid_after_last", 64'(s_axi_rvalid), 64'd0);
      checkOutput("arready_after_last", 64'(s_axi_arready), 64'd1);
    end else begin
      checkOutput("reached_stop_beat", 64'(k), 64'(stop_at));
    end
  endtask

  task automatic expectWords(input int first_word);
    for (int i = 0; i < 16; i++) begin
      exp_data[i]    = 64'(first_word + i);
      exp_resp[i]    = 2'b00;
      exp_data_on[i] = 1'b1;
    end
  endtask

  initial begin
    reset         = 1'b1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = 64'd0;
    s_axi_arlen   = 8'd0;
    s_axi_arsize  = 3'd0;
    s_axi_arburst = 2'd0;
    s_axi_rready  = 1'b0;
    load_en       = 1'b0;
    load_addr     = 64'd0;
    load_data     = 64'd0;

    repeat (3) @(negedge clk);
    checkOutput("reset_arready", 64'(s_axi_arready), 64'd0);
    checkOutput("reset_rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("reset_rlast", 64'(s_axi_rlast), 64'd0);
    checkOutput("reset_rresp", 64'(s_axi_rresp), 64'd0);
    checkOutput("reset_rdata", s_axi_rdata, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("arready_after_reset", 64'(s_axi_arready), 64'd1);

    // Word i holds value i for words 0..15; words 1022/1023 get a tag; word 1024 is out of range
    for (int i = 0; i < 19; i++) begin
      load_en   = 1'b1;
      load_addr = (i < 16) ? 64'(i * 8) : 64'((1006 + i) * 8);
      load_data = (i < 16) ? 64'(i) : 64'h5A00 + 64'(1006 + i);
      @(negedge clk);
    end
    load_en = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: INCR 8 beats from 0x40");
    expectWords(8);
    applyStimulus(64'h40, 8'd7, 3'd3, 2'd1);
    checkOutput("latency_edge0", 64'(s_axi_rvalid), 64'd0);
    @(negedge clk);
    checkOutput("latency_edge1", 64'(s_axi_rvalid), 64'd0);
    @(negedge clk);
    checkOutput("latency_edge2", 64'(s_axi_rvalid), 64'd1);
    collectBurst(8, 0, -1);

    $display("[TB] test 2: INCR with rready backpressure");
    applyStimulus(64'h40, 8'd7, 3'd3, 2'd1);
    collectBurst(8, 1, -1);

    $display("[TB] test 3: WRAP from 0x28");
    exp_data[0] = 64'd5; exp_data[1] = 64'd6; exp_data[2] = 64'd7; exp_data[3] = 64'd4;
    applyStimulus(64'h28, 8'd3, 3'd3, 2'd2);
    collectBurst(4, 0, -1);

    $display("[TB] test 4: INCR across end of memory");
    exp_data[0] = 64'h5A00 + 64'd1022; exp_data[1] = 64'h5A00 + 64'd1023;
    exp_data[2] = 64'd0;               exp_data[3] = 64'd0;
    exp_resp[2] = 2'b10;               exp_resp[3] = 2'b10;
    applyStimulus(64'((1024 - 2) * 8), 8'd3, 3'd3, 2'd1);
    collectBurst(4, 0, -1);

    $display("[TB] test 5: reserved burst type");
    expectWords(8);
    exp_resp[0] = 2'b10; exp_resp[1] = 2'b10;
    exp_data_on[0] = 1'b0; exp_data_on[1] = 1'b0;
    applyStimulus(64'h40, 8'd1, 3'd3, 2'd3);
    collectBurst(2, 0, -1);

    $display("[TB] test 6: reset during beat 3");
    expectWords(8);
    applyStimulus(64'h40, 8'd7, 3'd3, 2'd1);
    collectBurst(8, 0, 3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("midreset_arready", 64'(s_axi_arready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postreset_arready", 64'(s_axi_arready), 64'd1);
    repeat (4) @(negedge clk);
    checkOutput("postreset_no_beats", 64'(s_axi_rvalid), 64'd0);
    applyStimulus(64'h40, 8'd7, 3'd3, 2'd1);
    collectBurst(8, 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
